// File: rtl/flopr_pkg.sv
// Shared definitions for the flopr pipeline family: the occupancy counter width
// helper and the data value that invalid or cleared slots carry.
package flopr_pkg;

    localparam logic [63:0] DATA_CLR = '0;

    function automatic int clog2_plus1(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/flopr_en.sv
// Single pipeline stage: W-bit register with asynchronous active-high reset,
// synchronous clear (dominant over enable) and enable.
module flopr_en #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/flopr_pipe.sv
// WIDTH-bit, DEPTH-stage pipeline register with per-stage valid bits, stall,
// synchronous flush and a registered occupancy counter.
module flopr_pipe
    import flopr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = clog2_plus1(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    output logic [WIDTH-1:0] q,
    output logic [CW-1:0]    occupancy
);

    // Each stage word is {valid, data}.
    logic [WIDTH:0] stage   [DEPTH];
    logic [WIDTH:0] stage_d [DEPTH];
    logic [CW-1:0]  occ;

    assign stage_d[0] = {in_valid, in_valid ? d : WIDTH'(DATA_CLR)};

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i > 0) begin : g_link
            assign stage_d[i] = stage[i-1];
        end
        flopr_en #(
            .W(WIDTH + 1)
        ) u_stage (
            .clk  (clk),
            .reset(reset),
            .clr  (flush),
            .en   (en),
            .d    (stage_d[i]),
            .q    (stage[i])
        );
    end

    assign out_valid = stage[DEPTH-1][WIDTH];
    assign q         = stage[DEPTH-1][WIDTH-1:0];

    // Tracks the valid popcount incrementally; enter and leave on one edge cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            occ <= '0;
        else if (flush)
            occ <= '0;
        else if (en)
            occ <= occ + CW'(in_valid) - CW'(out_valid);
    end

    assign occupancy = occ;

endmodule

// File: tb/tb_flopr_pipe.sv
// Self-checking bench for flopr_pipe: directed scenarios plus random traffic
// against a history-based reference model; also a DEPTH=1, WIDTH=1 instance.
module tb_flopr_pipe;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset, en, flush, in_valid;
    logic [W-1:0]  d;
    logic          out_valid;
    logic [W-1:0]  q;
    logic [CW-1:0] occupancy;

    logic       reset1, en1, flush1, iv1;
    logic [0:0] d1, q1, occ1;
    logic       ov1;

    int checks = 0;
    int errors = 0;

    // Every word offered on an advancing edge since the last reset/flush: {valid, data}.
    logic [W:0] hist[$];

    always #5 clk = ~clk;

    flopr_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .d(d), .out_valid(out_valid), .q(q), .occupancy(occupancy)
    );

    flopr_pipe #(.WIDTH(1), .DEPTH(1)) dut1 (
        .clk(clk), .reset(reset1), .en(en1), .flush(flush1), .in_valid(iv1),
        .d(d1), .out_valid(ov1), .q(q1), .occupancy(occ1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // The output word is the one offered exactly D advancing edges ago.
    function automatic logic [W:0] exp_word();
        if (hist.size() >= D)
            return hist[hist.size() - D];
        return '0;
    endfunction

    function automatic int exp_occ();
        int n = 0;
        int lo = (hist.size() > D) ? hist.size() - D : 0;
        for (int i = lo; i < hist.size(); i++)
            if (hist[i][W]) n++;
        return n;
    endfunction

    task automatic check_all(input string tag);
        logic [W:0] w = exp_word();
        chk({tag, ".q"}, 32'(q), 32'(w[W-1:0]));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(w[W]));
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(exp_occ()));
    endtask

    task automatic drive(input logic e, input logic f, input logic v, input logic [W-1:0] dd);
        en = e; flush = f; in_valid = v; d = dd;
    endtask

    // One clock: update model at the rising edge, check after it and after the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        if (reset || flush)
            hist.delete();
        else if (en) begin
            hist.push_back({in_valid, in_valid ? d : W'(0)});
            if (hist.size() > D) void'(hist.pop_front());
        end
        #1 check_all({tag, ".rise"});
        @(negedge clk);
        #2 check_all({tag, ".fall"});
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        reset1 = 1'b1; en1 = 1'b0; flush1 = 1'b0; iv1 = 1'b0; d1 = '0;

        // Reset, then a stream of five words followed by bubbles.
        tick("reset");
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, W'(8'h11 * i));
            tick("stream");
        end
        chk("stream.occ_full", 32'(occupancy), 32'd4);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'hEE);
            tick("drain");
        end

        // Stall with two words in flight.
        drive(1'b1, 1'b0, 1'b1, 8'h11); tick("stall_in");
        drive(1'b1, 1'b0, 1'b1, 8'h22); tick("stall_in");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'h99);
            tick("stall_hold");
            chk("stall.occ", 32'(occupancy), 32'd2);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00);
            tick("stall_go");
        end

        // Bubble pattern: 0xFF offered with in_valid = 0 must not be captured.
        drive(1'b1, 1'b0, 1'b1, 8'hAA); tick("bubble");
        drive(1'b1, 1'b0, 1'b0, 8'hFF); tick("bubble");
        drive(1'b1, 1'b0, 1'b1, 8'hBB); tick("bubble");
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00);
            tick("bubble_drain");
            if (occupancy > 2) chk("bubble.occ_max", 32'(occupancy), 32'd2);
        end

        // Flush dominates en with a valid word on d.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, W'(8'hC0 + i));
            tick("flush_fill");
        end
        drive(1'b1, 1'b1, 1'b1, 8'h77); tick("flush");
        chk("flush.occ", 32'(occupancy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00);
            tick("flush_after");
            if (q == 8'h77) chk("flush.no77", 32'(q), 32'd0);
        end

        // Asynchronous reset between edges with a full pipeline.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, W'(8'hD0 + i));
            tick("areset_fill");
        end
        #1 reset = 1'b1;
        #1;
        chk("areset.q", 32'(q), 32'd0);
        chk("areset.out_valid", 32'(out_valid), 32'd0);
        chk("areset.occupancy", 32'(occupancy), 32'd0);
        hist.delete();
        drive(1'b1, 1'b0, 1'b1, 8'h5A);
        tick("areset_hold");
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 8'h3C); tick("areset_new");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00);
            tick("areset_lat");
        end
        chk("areset.latency_q", 32'(q), 32'h3C);
        chk("areset.latency_v", 32'(out_valid), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                  1'($urandom_range(0, 1)), W'($urandom));
            tick("random");
        end
        drive(1'b0, 1'b0, 1'b0, '0);

        // DEPTH=1, WIDTH=1 instance.
        @(posedge clk); #1;
        chk("d1.reset_q", 32'(q1), 32'd0);
        chk("d1.reset_v", 32'(ov1), 32'd0);
        @(negedge clk);
        reset1 = 1'b0; d1 = 1'b1; en1 = 1'b1; iv1 = 1'b1;
        #1 chk("d1.pre_edge_q", 32'(q1), 32'd0);
        @(posedge clk); #1;
        chk("d1.q", 32'(q1), 32'd1);
        chk("d1.v", 32'(ov1), 32'd1);
        chk("d1.occ", 32'(occ1), 32'd1);
        @(negedge clk);
        en1 = 1'b0; d1 = 1'b0; iv1 = 1'b0;
        @(posedge clk); #1;
        chk("d1.hold_q", 32'(q1), 32'd1);
        chk("d1.hold_v", 32'(ov1), 32'd1);
        @(negedge clk);
        en1 = 1'b1; flush1 = 1'b1; d1 = 1'b1; iv1 = 1'b1;
        @(posedge clk); #1;
        chk("d1.flush_q", 32'(q1), 32'd0);
        chk("d1.flush_occ", 32'(occ1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
